cc_deserializer: RTL



---
 rtl/cc_deserializer_pkg.sv | 21 ++
 rtl/cc_deserializer_if.sv | 29 ++
 rtl/cc_deserializer.sv | 80 ++++++++
 3 files changed

// File: rtl/cc_deserializer_pkg.sv
// Shared widths and FSM state type for the cache-line fill path.
package cc_pkg;

  localparam int unsigned CC_BEAT_W   = 64;
  localparam int unsigned CC_BEATS    = 8;
  localparam int unsigned CC_LINE_W   = 512;
  localparam int unsigned CC_OFFSET_W = 6;
  localparam int unsigned CC_FIFO_W   = 518;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PUSH
  } cc_deser_state_t;

  // Address-ordered word slot for a wrap-burst beat.
  function automatic logic [2:0] cc_slot(input logic [2:0] crit, input logic [2:0] beat);
    return crit + beat;
  endfunction

endpackage

// File: rtl/cc_deserializer_if.sv
// Miss-request, memory read-beat and data-FIFO write signals of the line-fill assembler.
interface cc_deserializer_if;
  import cc_pkg::*;

  logic                   miss_req_valid_i;
  logic [CC_OFFSET_W-1:0] miss_req_offset_i;
  logic                   miss_req_ready_o;
  logic [CC_BEAT_W-1:0]   mem_rdata_i;
  logic                   mem_rlast_i;
  logic                   mem_rvalid_i;
  logic                   mem_rready_o;
  logic                   fifo_full_i;
  logic                   fifo_wren_o;
  logic [CC_FIFO_W-1:0]   fifo_wdata_o;
  logic                   protocol_err_o;

  modport master (
    output miss_req_valid_i, miss_req_offset_i, mem_rdata_i, mem_rlast_i,
           mem_rvalid_i, fifo_full_i,
    input  miss_req_ready_o, mem_rready_o, fifo_wren_o, fifo_wdata_o, protocol_err_o
  );

  modport slave (
    input  miss_req_valid_i, miss_req_offset_i, mem_rdata_i, mem_rlast_i,
           mem_rvalid_i, fifo_full_i,
    output miss_req_ready_o, mem_rready_o, fifo_wren_o, fifo_wdata_o, protocol_err_o
  );

endinterface

// File: rtl/cc_deserializer.sv
// Assembles an 8-beat wrap burst into an address-ordered line and pushes {offset, line}
// into the serializer's data FIFO.
module cc_deserializer
  import cc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  cc_deserializer_if.slave bus
);

  cc_deser_state_t        state;
  logic [2:0]             beat_cnt;
  logic [CC_OFFSET_W-1:0] offset;
  logic [CC_BEAT_W-1:0]   line [CC_BEATS];
  logic                   protocol_err;

  logic                   beat_fire;
  logic [2:0]             slot;
  logic [CC_BEATS-1:0]    slot_we;
  logic                   last_beat;
  logic                   rlast_bad;
  logic [CC_FIFO_W-1:0]   wdata;

  always_comb begin
    beat_fire = (state == ST_COLLECT) && bus.mem_rvalid_i;
    slot      = cc_slot(offset[5:3], beat_cnt);
    slot_we   = '0;
    if (beat_fire) slot_we[slot] = 1'b1;
    last_beat = (beat_cnt == 3'd7);
    // rlast must appear exactly on the eighth beat
    rlast_bad = (bus.mem_rlast_i != last_beat);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      offset       <= '0;
      protocol_err <= 1'b0;
      for (int unsigned i = 0; i < CC_BEATS; i++) line[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CC_BEATS; i++)
        if (slot_we[i]) line[i] <= bus.mem_rdata_i;
      case (state)
        ST_IDLE: begin
          if (bus.miss_req_valid_i) begin
            offset   <= bus.miss_req_offset_i;
            beat_cnt <= '0;
            state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (rlast_bad) protocol_err <= 1'b1;
            if (last_beat) state <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (!bus.fifo_full_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wdata = '0;
    wdata[CC_FIFO_W-1 -: CC_OFFSET_W] = offset;
    for (int unsigned k = 0; k < CC_BEATS; k++)
      wdata[CC_LINE_W-1-CC_BEAT_W*k -: CC_BEAT_W] = line[k];
  end

  assign bus.miss_req_ready_o = (state == ST_IDLE);
  assign bus.mem_rready_o     = (state == ST_COLLECT);
  assign bus.fifo_wren_o      = (state == ST_PUSH) && !bus.fifo_full_i;
  assign bus.fifo_wdata_o     = wdata;
  assign bus.protocol_err_o   = protocol_err;

endmodule
